// File: rtl/cruce_pkg.sv
// Shared definitions for the crossing monitor: light codes, fault codes and the
// supervisor state enum.
package cruce_pkg;

    localparam logic [1:0] ROJO         = 2'b00;
    localparam logic [1:0] VERDE        = 2'b01;
    localparam logic [1:0] AMARILLO     = 2'b10;
    localparam logic [1:0] LUZ_INVALIDA = 2'b11;

    localparam logic [2:0] FALLA_NINGUNA   = 3'd0;
    localparam logic [2:0] FALLA_CONFLICTO = 3'd1;
    localparam logic [2:0] FALLA_INVALIDO  = 3'd2;
    localparam logic [2:0] FALLA_TRANSICION = 3'd3;
    localparam logic [2:0] FALLA_AMARILLO_CORTO = 3'd4;
    localparam logic [2:0] FALLA_VERDE_CORTO = 3'd5;
    localparam logic [2:0] FALLA_WATCHDOG  = 3'd6;

    typedef enum logic {
        ARMADO = 1'b0,
        FALLA  = 1'b1
    } estado_t;

    // One step forward in the ROJO->VERDE->AMARILLO->ROJO cycle.
    function automatic logic paso_legal(input logic [1:0] prev, input logic [1:0] cur);
        return ((prev == ROJO)     && (cur == VERDE))    ||
               ((prev == VERDE)    && (cur == AMARILLO)) ||
               ((prev == AMARILLO) && (cur == ROJO));
    endfunction

endpackage

// File: rtl/cruce_monitor_via.sv
// Per-approach tracker: remembers the previous light code and how long it has
// been held, and flags invalid codes, illegal changes and short phases.
module cruce_monitor_via
    import cruce_pkg::*;
#(
    parameter int MIN_VERDE    = 4,
    parameter int MIN_AMARILLO = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic [1:0] luz,
    output logic       cambio,
    output logic       invalido,
    output logic       transicion,
    output logic       amarillo_corto,
    output logic       verde_corto
);

    localparam int DWELL_MAX = (MIN_VERDE > MIN_AMARILLO) ? MIN_VERDE : MIN_AMARILLO;
    localparam int DWELL_W   = $clog2(DWELL_MAX + 2);
    localparam logic [DWELL_W-1:0] MIN_V = DWELL_W'(MIN_VERDE);
    localparam logic [DWELL_W-1:0] MIN_A = DWELL_W'(MIN_AMARILLO);

    logic [1:0]         prev;
    logic [DWELL_W-1:0] dwell;

    always_comb begin
        cambio         = (luz != prev);
        invalido       = (luz == LUZ_INVALIDA);
        // Leaving an invalid code is not itself a sequence fault; it was already reported.
        transicion     = cambio && !invalido && (prev != LUZ_INVALIDA) && !paso_legal(prev, luz);
        amarillo_corto = (prev == AMARILLO) && (luz == ROJO)     && (dwell < MIN_A);
        verde_corto    = (prev == VERDE)    && (luz == AMARILLO) && (dwell < MIN_V);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev  <= ROJO;
            dwell <= '0;
        end else if (enb) begin
            if (cambio) begin
                prev  <= luz;
                dwell <= DWELL_W'(1);
            end else if (dwell != '1) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cruce_monitor.sv
// Safety supervisor for the two-approach crossing. Build with CRUCE_WATCHDOG_EN
// defined to include the no-change watchdog (fault 6).
module cruce_monitor
    import cruce_pkg::*;
#(
    parameter int MIN_VERDE    = 4,
    parameter int MIN_AMARILLO = 2,
    parameter int TIMEOUT      = 64,
    parameter int CONT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              limpiar,
    input  logic [1:0]        semaforo_A,
    input  logic [1:0]        semaforo_B,
    output logic              falla,
    output logic [2:0]        codigo_falla,
    output logic              forzar_rojo,
    output logic [CONT_W-1:0] conteo_fallas
);

    logic cambio_a, invalido_a, transicion_a, amarillo_corto_a, verde_corto_a;
    logic cambio_b, invalido_b, transicion_b, amarillo_corto_b, verde_corto_b;
    logic wd_det;

    cruce_monitor_via #(.MIN_VERDE(MIN_VERDE), .MIN_AMARILLO(MIN_AMARILLO)) u_via_a (
        .clk            (clk),
        .reset          (reset),
        .enb            (enb),
        .luz            (semaforo_A),
        .cambio         (cambio_a),
        .invalido       (invalido_a),
        .transicion     (transicion_a),
        .amarillo_corto (amarillo_corto_a),
        .verde_corto    (verde_corto_a)
    );

    cruce_monitor_via #(.MIN_VERDE(MIN_VERDE), .MIN_AMARILLO(MIN_AMARILLO)) u_via_b (
        .clk            (clk),
        .reset          (reset),
        .enb            (enb),
        .luz            (semaforo_B),
        .cambio         (cambio_b),
        .invalido       (invalido_b),
        .transicion     (transicion_b),
        .amarillo_corto (amarillo_corto_b),
        .verde_corto    (verde_corto_b)
    );

`ifdef CRUCE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;

    // wd_cnt counts samples the current light pair has been held, change sample included.
    assign wd_det = !cambio_a && !cambio_b && (wd_cnt >= WD_LIM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (enb) begin
            if (cambio_a || cambio_b) begin
                wd_cnt <= WD_W'(1);
            end else if (wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT;
    assign wd_det = 1'b0;
`endif

    logic [2:0] codigo_det;
    logic       hay_det;
    estado_t    estado, estado_sig;
    logic [2:0] codigo_sig;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        codigo_det = FALLA_NINGUNA;
        if (enb) begin
            if ((semaforo_A != ROJO) && (semaforo_B != ROJO)) codigo_det = FALLA_CONFLICTO;
            else if (invalido_a || invalido_b)                codigo_det = FALLA_INVALIDO;
            else if (transicion_a || transicion_b)            codigo_det = FALLA_TRANSICION;
            else if (amarillo_corto_a || amarillo_corto_b)    codigo_det = FALLA_AMARILLO_CORTO;
            else if (verde_corto_a || verde_corto_b)          codigo_det = FALLA_VERDE_CORTO;
            else if (wd_det)                                  codigo_det = FALLA_WATCHDOG;
        end
        hay_det = (codigo_det != FALLA_NINGUNA);
    end

    always_comb begin
        estado_sig = estado;
        codigo_sig = codigo_falla;
        case (estado)
            ARMADO: begin
                if (hay_det) begin
                    estado_sig = FALLA;
                    codigo_sig = codigo_det;
                end
            end
            FALLA: begin
                // The first code is sticky until limpiar; a detection during limpiar re-arms with it.
                if (limpiar) begin
                    if (hay_det) begin
                        codigo_sig = codigo_det;
                    end else begin
                        estado_sig = ARMADO;
                        codigo_sig = FALLA_NINGUNA;
                    end
                end
            end
            default: begin
                estado_sig = ARMADO;
                codigo_sig = FALLA_NINGUNA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado        <= ARMADO;
            codigo_falla  <= FALLA_NINGUNA;
            conteo_fallas <= '0;
        end else begin
            estado       <= estado_sig;
            codigo_falla <= codigo_sig;
            if (hay_det && (conteo_fallas != '1)) begin
                conteo_fallas <= conteo_fallas + 1'b1;
            end
        end
    end

    assign falla       = (estado == FALLA);
    assign forzar_rojo = falla;

endmodule

// File: tb/tb_cruce_monitor.sv
// Directed self-checking bench for cruce_monitor with default parameters; the
// watchdog expectation follows CRUCE_WATCHDOG_EN.
module tb_cruce_monitor;
    import cruce_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic       limpiar;
    logic [1:0] semaforo_A;
    logic [1:0] semaforo_B;
    logic       falla;
    logic [2:0] codigo_falla;
    logic       forzar_rojo;
    logic [7:0] conteo_fallas;

    int n_checks = 0;
    int n_fail   = 0;

    cruce_monitor #(
        .MIN_VERDE    (4),
        .MIN_AMARILLO (2),
        .TIMEOUT      (64),
        .CONT_W       (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enb           (enb),
        .limpiar       (limpiar),
        .semaforo_A    (semaforo_A),
        .semaforo_B    (semaforo_B),
        .falla         (falla),
        .codigo_falla  (codigo_falla),
        .forzar_rojo   (forzar_rojo),
        .conteo_fallas (conteo_fallas)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic f, input logic [2:0] c, input logic [7:0] n);
        check({tag, ".falla"}, 32'(falla), 32'(f));
        check({tag, ".codigo"}, 32'(codigo_falla), 32'(c));
        check({tag, ".forzar"}, 32'(forzar_rojo), 32'(f));
        check({tag, ".conteo"}, 32'(conteo_fallas), 32'(n));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
    endtask

    logic [1:0] seq_a [8];

    initial begin
        reset      = 1'b0;
        enb        = 1'b0;
        limpiar    = 1'b0;
        semaforo_A = ROJO;
        semaforo_B = ROJO;
        tick(2);
        check_all("reset", 1'b0, 3'd0, 8'd0);

        // Legal full cycle on A, B held red.
        reset = 1'b1;
        enb   = 1'b1;
        seq_a = '{ROJO, VERDE, VERDE, VERDE, VERDE, AMARILLO, AMARILLO, ROJO};
        for (int i = 0; i < 8; i++) begin
            semaforo_A = seq_a[i];
            tick(1);
            check($sformatf("legal[%0d].falla", i), 32'(falla), 32'd0);
            check($sformatf("legal[%0d].conteo", i), 32'(conteo_fallas), 32'd0);
        end

        // Conflicting greens for three samples.
        semaforo_A = VERDE;
        semaforo_B = VERDE;
        tick(1);
        check_all("conflict1", 1'b1, 3'd1, 8'd1);
        tick(2);
        check_all("conflict3", 1'b1, 3'd1, 8'd3);

        // Short green, then invalid B keeps the sticky code.
        do_reset();
        semaforo_A = VERDE;
        semaforo_B = ROJO;
        tick(2);
        check_all("green2", 1'b0, 3'd0, 8'd0);
        semaforo_A = AMARILLO;
        tick(1);
        check_all("short_green", 1'b1, 3'd5, 8'd1);
        semaforo_B = LUZ_INVALIDA;
        tick(1);
        check_all("sticky", 1'b1, 3'd5, 8'd2);

        // Illegal VERDE->ROJO, then clear.
        do_reset();
        semaforo_A = VERDE;
        semaforo_B = ROJO;
        tick(1);
        semaforo_A = ROJO;
        tick(1);
        check_all("trans", 1'b1, 3'd3, 8'd1);
        limpiar = 1'b1;
        tick(1);
        check_all("clear", 1'b0, 3'd0, 8'd1);
        limpiar    = 1'b0;
        semaforo_A = AMARILLO;
        tick(1);
        check_all("rojo_amarillo", 1'b1, 3'd3, 8'd2);
        // Clear coinciding with a new detection loads the new code.
        limpiar    = 1'b1;
        semaforo_B = LUZ_INVALIDA;
        tick(1);
        check_all("clear_det", 1'b1, 3'd1, 8'd3);
        // Clear works with enb low.
        enb = 1'b0;
        tick(1);
        check_all("clear_noenb", 1'b0, 3'd0, 8'd3);

        // Disabled sampling ignores conflicting greens.
        limpiar    = 1'b0;
        semaforo_A = VERDE;
        semaforo_B = VERDE;
        tick(100);
        check_all("enb0", 1'b0, 3'd0, 8'd3);
        enb = 1'b1;
        tick(1);
        check_all("enb1", 1'b1, 3'd1, 8'd4);
        reset = 1'b0;
        tick(1);
        check_all("midreset", 1'b0, 3'd0, 8'd0);

        // Watchdog: A green, B red held for 64 enabled samples.
        reset      = 1'b1;
        semaforo_A = VERDE;
        semaforo_B = ROJO;
        tick(63);
        check_all("wd63", 1'b0, 3'd0, 8'd0);
        tick(1);
`ifdef CRUCE_WATCHDOG_EN
        check_all("wd64", 1'b1, 3'd6, 8'd1);
`else
        check_all("wd64", 1'b0, 3'd0, 8'd0);
`endif

        // Counter saturation.
        do_reset();
        semaforo_A = VERDE;
        semaforo_B = VERDE;
        tick(254);
        check_all("sat254", 1'b1, 3'd1, 8'd254);
        tick(46);
        check_all("sat255", 1'b1, 3'd1, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cruce_monitor.md
# cruce_monitor

Safety supervisor for the two-approach vehicular crossing. It sits on the far end of the light-control interface and consumes the `semaforo_A`/`semaforo_B` codes produced by the crossing controller. It checks every enabled sample for conflicting greens, invalid codes, illegal colour sequences and too-short phases. It latches the first fault, counts violations and raises an all-red override request.

## Interface
Parameters:
- `MIN_VERDE`, 4: minimum enabled samples a green must hold before turning yellow.
- `MIN_AMARILLO`, 2: minimum enabled samples a yellow must hold before turning red.
- `TIMEOUT`, 64: enabled samples without any light change before the watchdog fault fires. Only used when the watchdog is compiled in.
- `CONT_W`, 8: width of the violation counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `enb`  in  1: sample enable. When 0, all state holds and no checks run.
- `limpiar`  in  1: clears a latched fault.
- `semaforo_A`  in  2: light code for approach A.
- `semaforo_B`  in  2: light code for approach B.
- `falla`  out  1: latched fault flag.
- `codigo_falla`  out  3: code of the first latched fault; 0 when no fault is latched.
- `forzar_rojo`  out  1: all-red override request; equal to `falla`.
- `conteo_fallas`  out  CONT_W: saturating count of violation detections.

## Operation
- Light encoding: ROJO=2'b00, VERDE=2'b01, AMARILLO=2'b10. 2'b11 is invalid.
- Per approach, the block keeps the previous code (`prev`) and a dwell count of consecutive enabled samples holding that code.
  - When the code changes, dwell is set to 1.
  - Otherwise dwell increments and saturates.
- Legal sequence per approach: ROJO→VERDE→AMARILLO→ROJO. Holding the same code is always legal.
- Fault codes, checked on every sample with `enb`=1. When several apply in the same cycle, the lowest code number wins.
  - 1 CONFLICTO: A≠ROJO and B≠ROJO.
  - 2 INVALIDO: either code is 2'b11.
  - 3 TRANSICION: any other change, i.e. VERDE→ROJO, AMARILLO→VERDE or ROJO→AMARILLO.
  - 4 AMARILLO_CORTO: AMARILLO→ROJO with dwell < MIN_AMARILLO.
  - 5 VERDE_CORTO: VERDE→AMARILLO with dwell < MIN_VERDE.
  - 6 WATCHDOG: neither code has changed for TIMEOUT samples.
- States:
  - ARMADO: no fault latched. Any detection moves to FALLA and latches its code.
  - FALLA: `codigo_falla` is sticky and later faults do not overwrite it. `limpiar`=1 with no detection in the same cycle returns to ARMADO with the code cleared to 0. `limpiar` together with a detection stays in FALLA and loads the new code.
- `conteo_fallas` increments by 1 on every enabled sample with at least one detection, in either state. It saturates at 2^CONT_W−1.
- `limpiar` is honoured regardless of `enb`.

## Timing
- Reset (`reset`=0 at a rising edge):
  - `falla`=0, `forzar_rojo`=0, `codigo_falla`=0, `conteo_fallas`=0.
  - State ARMADO; both `prev`=ROJO; both dwell counts=0; watchdog count=0.
- Reset mid-operation discards every latched fault and count at that edge.
- Latency: a violation sampled at edge N is visible on the outputs after edge N. All outputs are registered.
- With `enb`=0: inputs are ignored, and `prev`, dwell, the watchdog count and the violation count hold.
- After reset, the first enabled sample is compared against `prev`=ROJO. VERDE on the first sample is therefore legal; AMARILLO on the first sample is fault 3.

## Configuration
- `CRUCE_WATCHDOG_EN` defined: the TIMEOUT counter is built and fault 6 is active. The counter resets whenever either code changes.
- `CRUCE_WATCHDOG_EN` not defined: no watchdog counter exists, code 6 is never produced, and `TIMEOUT` is unused.

## Structure
- Shared package `cruce_pkg`: light-code constants, the fault-code constants 0–6, and the monitor state enum.
- Sub-module `cruce_monitor_via`, instantiated once per approach. It holds that approach's `prev` and dwell registers and outputs per-approach flags for invalid code, illegal transition, short yellow and short green.
- The top level handles conflict detection, fault priority, the FSM, the counter and the watchdog.

## Test plan
- Reset, then A: ROJO→VERDE×4→AMARILLO×2→ROJO while B stays ROJO → `falla`=0 and `conteo_fallas`=0 throughout.
- A=VERDE and B=VERDE for 3 samples → `falla`=1 one edge later, `codigo_falla`=1, `conteo_fallas`=3.
- A: VERDE×2 then AMARILLO (MIN_VERDE=4) → code 5. Then B=2'b11 → code stays 5 and the counter increments.
- A: VERDE→ROJO → code 3. Assert `limpiar` with legal inputs → next edge `falla`=0, `codigo_falla`=0, counter retained.
- `enb`=0 for 100 cycles while A=VERDE and B=VERDE → no fault and counter unchanged. Pull `reset` low mid-FALLA → all outputs return to 0.
- With `CRUCE_WATCHDOG_EN`: hold A=VERDE, B=ROJO for 64 enabled samples → code 6. Without the macro, the same stimulus leaves `falla`=0.
